// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parameterised UART transmitter (start, data LSB first,
// optional parity, 1 or 2 stop bits) fed by a small write FIFO so the host
// can queue several words back to back.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 5208,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          write,
  input  logic [DATA_BITS-1:0]          data,
  output logic                          txrdy,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLK_DIV - 1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);
  localparam logic [3:0]    D_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    S_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Parity of a data word; odd parity is the inverted XOR.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  state_t               r_state;
  logic [TW-1:0]        r_timer;
  logic [3:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx;
  logic                 r_overflow;
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]        r_wp;
  logic [PW-1:0]        r_rp;
  logic [CW-1:0]        r_count;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_tick;
  logic                 w_tx_next;
  logic [DATA_BITS-1:0] w_head;

  assign w_full  = (r_count == C_FULL);
  assign w_empty = (r_count == {CW{1'b0}});
  assign w_push  = write & ~w_full;
  assign w_tick  = (r_timer == T_LAST);
  assign w_head  = r_mem[r_rp];

  // Pop the FIFO head when idle, or at the very last stop-bit cycle.
  always_comb begin
    w_pop = 1'b0;
    if (w_empty) begin
      w_pop = 1'b0;
    end else if (r_state == S_IDLE) begin
      w_pop = 1'b1;
    end else if ((r_state == S_STOP) && w_tick && (r_bit == S_LAST)) begin
      w_pop = 1'b1;
    end else begin
      w_pop = 1'b0;
    end
  end

  // Line level for the current state; registered one cycle later into r_tx.
  always_comb begin
    w_tx_next = 1'b1;
    case (r_state)
      S_IDLE:   w_tx_next = 1'b1;
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = r_shift[0];
      S_PARITY: w_tx_next = r_par;
      S_STOP:   w_tx_next = 1'b1;
      default:  w_tx_next = 1'b1;
    endcase
  end

  // FIFO storage, pointers, occupancy and the overflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= {DATA_BITS{1'b0}};
      r_wp       <= {PW{1'b0}};
      r_rp       <= {PW{1'b0}};
      r_count    <= {CW{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= data;
        r_wp        <= r_wp + PW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_overflow <= write & w_full;
    end
  end

  // Frame sequencer: bit timer, bit counter, shift register and tx register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_timer <= {TW{1'b0}};
      r_bit   <= 4'd0;
      r_shift <= {DATA_BITS{1'b0}};
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_tx <= w_tx_next;
      case (r_state)
        S_IDLE: begin
          r_timer <= {TW{1'b0}};
          r_bit   <= 4'd0;
          if (w_pop) begin
            r_shift <= w_head;
            r_par   <= parity_of(w_head);
            r_state <= S_START;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_timer <= {TW{1'b0}};
            r_bit   <= 4'd0;
            r_state <= S_DATA;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_timer <= {TW{1'b0}};
            r_shift <= r_shift >> 1;
            if (r_bit == D_LAST) begin
              r_bit   <= 4'd0;
              r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end else begin
              r_bit <= r_bit + 4'd1;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            r_timer <= {TW{1'b0}};
            r_bit   <= 4'd0;
            r_state <= S_STOP;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_timer <= {TW{1'b0}};
            if (r_bit == S_LAST) begin
              r_bit <= 4'd0;
              if (w_pop) begin
                r_shift <= w_head;
                r_par   <= parity_of(w_head);
                r_state <= S_START;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_bit <= r_bit + 4'd1;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_timer <= {TW{1'b0}};
          r_bit   <= 4'd0;
        end
      endcase
    end
  end

  assign tx         = r_tx;
  assign overflow   = r_overflow;
  assign fifo_count = r_count;
  assign txrdy      = ~w_full;
  assign busy       = (r_state != S_IDLE) | ~w_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: three transmitter configurations (8N1, 7O2, 7E2) checked
// every cycle against a frame-level queue model, plus hand-computed points.
module tb_uart_tx_fifo;

  localparam int CD    = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] wr = 3'b000;
  logic [8:0] dat [3];
  logic [2:0] tx_o;
  logic [2:0] busy_o;
  logic [2:0] txrdy_o;
  logic [2:0] ovf_o;
  logic [2:0] cnt_o [3];

  int n_chk = 0;
  int n_bad = 0;

  // Free-running clock.
  initial forever #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DB   = (g == 0) ? 8 : 7;
    localparam int PE   = (g == 0) ? 0 : 1;
    localparam int PO   = (g == 1) ? 1 : 0;
    localparam int SB   = (g == 0) ? 1 : 2;
    localparam int FLEN = (1 + DB + PE + SB) * CD;

    uart_tx_fifo #(
      .CLK_DIV(CD), .DATA_BITS(DB), .PARITY_EN(PE), .PARITY_ODD(PO),
      .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .write(wr[g]), .data(dat[g][DB-1:0]),
      .txrdy(txrdy_o[g]), .tx(tx_o[g]), .busy(busy_o[g]),
      .fifo_count(cnt_o[g]), .overflow(ovf_o[g])
    );

    logic [8:0] q [$];
    bit         wave [$];
    int         rem = 0;
    int         pre = 0;
    logic [8:0] w = 9'd0;
    logic       e_tx = 1'b1;
    logic       e_ovf = 1'b0;
    int         n_chk = 0;
    int         n_bad = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL g%0d %s @%0t: got %0h want %0h", g, nm, $time, act, exp);
      end
    endtask

    // Frame-level model: queued words, remaining frame cycles, expected line samples.
    initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        wave.delete();
        rem   = 0;
        e_tx  = 1'b1;
        e_ovf = 1'b0;
      end else begin
        pre  = q.size();
        e_tx = (wave.size() > 0) ? wave.pop_front() : 1'b1;
        if (rem > 1) begin
          rem--;
        end else if (q.size() > 0) begin
          w = q.pop_front();
          for (int k = 0; k < CD; k++) wave.push_back(1'b0);
          for (int d = 0; d < DB; d++)
            for (int k = 0; k < CD; k++) wave.push_back(w[d]);
          if (PE != 0)
            for (int k = 0; k < CD; k++) wave.push_back((^w) ^ (PO != 0));
          for (int k = 0; k < SB * CD; k++) wave.push_back(1'b1);
          rem = FLEN;
        end else begin
          rem = 0;
        end
        e_ovf = wr[g] && (pre == DEPTH);
        if (wr[g] && (pre != DEPTH)) q.push_back(dat[g] & ((9'd1 << DB) - 9'd1));
      end
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
      @(negedge clk);
      if (rst_n) begin
        cmp("tx",         32'(tx_o[g]),    32'(e_tx));
        cmp("fifo_count", 32'(cnt_o[g]),   32'(q.size()));
        cmp("txrdy",      32'(txrdy_o[g]), 32'(q.size() != DEPTH));
        cmp("busy",       32'(busy_o[g]),  32'((rem != 0) || (q.size() != 0)));
        cmp("overflow",   32'(ovf_o[g]),   32'(e_ovf));
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy_o != 3'b000) && (n < budget)) begin
      step();
      n++;
    end
    chk("idle_within_budget", 32'(busy_o), 32'd0);
  endtask

  // Directed scenarios, randomized traffic, then the summary line.
  initial begin
    int total;
    int bad;
    logic [7:0] a5;
    logic [6:0] v3;
    a5 = 8'hA5;
    v3 = 7'h03;
    for (int i = 0; i < 3; i++) dat[i] = 9'd0;

    // Reset and idle.
    repeat (5) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx_o), 32'h7);
    chk("rst_txrdy", 32'(txrdy_o), 32'h7);
    rst_n = 1'b1;
    repeat (200) step();
    chk("idle_tx", 32'(tx_o), 32'h7);
    chk("idle_busy", 32'(busy_o), 32'h0);
    chk("idle_cnt0", 32'(cnt_o[0]), 32'd0);

    // Single 8N1 frame of 0xA5.
    wr[0] = 1'b1; dat[0] = 9'h0A5;
    step();                                   // edge N
    wr[0] = 1'b0;
    chk("a5_cnt_after_write", 32'(cnt_o[0]), 32'd1);
    step();                                   // N+1: popped
    chk("a5_tx_n1", 32'(tx_o[0]), 32'd1);
    chk("a5_cnt_after_pop", 32'(cnt_o[0]), 32'd0);
    chk("a5_busy_n1", 32'(busy_o[0]), 32'd1);
    step();                                   // N+2: start bit
    chk("a5_tx_fall", 32'(tx_o[0]), 32'd0);
    repeat (8) step();
    chk("a5_start_mid", 32'(tx_o[0]), 32'd0);
    for (int k = 0; k < 8; k++) begin
      repeat (16) step();
      chk("a5_data_bit", 32'(tx_o[0]), 32'(a5[k]));
    end
    repeat (16) step();
    chk("a5_stop", 32'(tx_o[0]), 32'd1);
    repeat (6) step();                        // N+160
    chk("a5_busy_last", 32'(busy_o[0]), 32'd1);
    step();                                   // N+161
    chk("a5_busy_drop", 32'(busy_o[0]), 32'd0);

    // 7-bit frames of 0x03: odd parity on instance 1, even on instance 2.
    wr[1] = 1'b1; wr[2] = 1'b1; dat[1] = 9'h003; dat[2] = 9'h003;
    step();
    wr[1] = 1'b0; wr[2] = 1'b0;
    repeat (2) step();
    chk("p_tx_fall", 32'(tx_o[2:1]), 32'd0);
    repeat (8) step();
    for (int k = 0; k < 7; k++) begin
      repeat (16) step();
      chk("p_data_bit_odd", 32'(tx_o[1]), 32'(v3[k]));
      chk("p_data_bit_even", 32'(tx_o[2]), 32'(v3[k]));
    end
    repeat (16) step();
    chk("p_parity_odd", 32'(tx_o[1]), 32'd1);
    chk("p_parity_even", 32'(tx_o[2]), 32'd0);
    repeat (16) step();
    chk("p_stop1", 32'(tx_o[2:1]), 32'h3);
    repeat (16) step();
    chk("p_stop2", 32'(tx_o[2:1]), 32'h3);
    repeat (6) step();
    chk("p_busy_last", 32'(busy_o[2:1]), 32'h3);
    step();
    chk("p_busy_drop", 32'(busy_o[2:1]), 32'h0);

    // Back-to-back writes until full, then one dropped write.
    wr[0] = 1'b1;
    dat[0] = 9'h011; step();                  // N
    dat[0] = 9'h022; step();                  // N+1 (pop + push)
    dat[0] = 9'h033; step();
    dat[0] = 9'h044; step();
    dat[0] = 9'h055; step();                  // N+4
    chk("full_txrdy", 32'(txrdy_o[0]), 32'd0);
    chk("full_cnt", 32'(cnt_o[0]), 32'd4);
    dat[0] = 9'h066; step();                  // N+5 dropped
    wr[0] = 1'b0;
    chk("drop_overflow", 32'(ovf_o[0]), 32'd1);
    chk("drop_cnt", 32'(cnt_o[0]), 32'd4);
    step();
    chk("drop_overflow_end", 32'(ovf_o[0]), 32'd0);
    repeat (155) step();                      // N+161
    chk("b2b_last_stop", 32'(tx_o[0]), 32'd1);
    step();                                   // N+162
    chk("b2b_next_start", 32'(tx_o[0]), 32'd0);
    wait_idle(2000);

    // Push on the same cycle as the end-of-stop pop with two words queued.
    wr[0] = 1'b1;
    dat[0] = 9'h001; step();                  // N
    dat[0] = 9'h002; step();
    dat[0] = 9'h003; step();                  // N+2
    wr[0] = 1'b0;
    repeat (158) step();                      // N+160
    chk("pp_cnt_before", 32'(cnt_o[0]), 32'd2);
    wr[0] = 1'b1; dat[0] = 9'h05A;
    step();                                   // N+161
    wr[0] = 1'b0;
    chk("pp_cnt_after", 32'(cnt_o[0]), 32'd2);
    chk("pp_no_overflow", 32'(ovf_o[0]), 32'd0);
    wait_idle(2000);

    // Reset in the middle of a frame of zero bits.
    wr[0] = 1'b1; dat[0] = 9'h000;
    step();
    wr[0] = 1'b0;
    repeat (39) step();
    chk("mid_tx_low", 32'(tx_o[0]), 32'd0);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(tx_o), 32'h7);
    chk("mid_rst_busy", 32'(busy_o), 32'h0);
    chk("mid_rst_txrdy", 32'(txrdy_o), 32'h7);
    chk("mid_rst_cnt", 32'(cnt_o[0]), 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (300) step();
    chk("post_rst_tx", 32'(tx_o), 32'h7);
    chk("post_rst_busy", 32'(busy_o), 32'h0);

    // Randomized traffic on all three instances.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        wr[i]  = ($urandom_range(0, 99) < 4);
        dat[i] = 9'($urandom);
      end
      step();
    end
    wr = 3'b000;
    wait_idle(3000);

    total = n_chk + g_dut[0].n_chk + g_dut[1].n_chk + g_dut[2].n_chk;
    bad   = n_bad + g_dut[0].n_bad + g_dut[1].n_bad + g_dut[2].n_bad;
    $display("%0d/%0d checks passed", total - bad, total);
    $finish;
  end

endmodule
